// File: rtl/pipe_add_n_if.sv
// Operand/result bus of the pipelined adder: valid/ready on both sides.
// The producer/consumer side uses "master"; the adder itself uses "slave".
interface pipe_add_n_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, op, cin, a, b, out_ready,
        input  in_ready, out_valid, sum, carry, overflow, zero
    );

    modport slave (
        input  in_valid, op, cin, a, b, out_ready,
        output in_ready, out_valid, sum, carry, overflow, zero
    );
endinterface

// File: rtl/pipe_add_n.sv
// Pipelined add/sub/inc/adc unit. The WIDTH-bit carry chain is cut into STAGES
// segments of SEG bits; each stage ripples one segment and registers its carry,
// while operands and finished sum bits travel along with the beat.
// The last stage register doubles as the output register.
module pipe_add_n #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    pipe_add_n_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;

    localparam logic [1:0]        OP_ADD    = 2'b00;
    localparam logic [1:0]        OP_SUB    = 2'b01;
    localparam logic [1:0]        OP_INC    = 2'b10;
    localparam logic [1:0]        OP_ADC    = 2'b11;
    localparam logic [STAGES-1:0] ALL_VALID = {STAGES{1'b1}};

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipe_add_n: STAGES must be >= 1 and divide WIDTH");
    end

    // Stage state: beat valid, operands, partial sum, carry out of the stage's segment
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic              ovf_q;
    logic              zero_q;

    // What each stage would capture: upstream register or the entry port
    logic [STAGES-1:0] src_vld_s;
    logic [WIDTH-1:0]  src_a_s [STAGES];
    logic [WIDTH-1:0]  src_b_s [STAGES];
    logic [WIDTH-1:0]  src_s_s [STAGES];
    logic [STAGES-1:0] src_c_s;

    logic [SEG:0]      seg_s [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];
    logic              ovf_d;
    logic              zero_d;
    logic [STAGES-1:0] rdy_s;
    logic [WIDTH-1:0]  b_eff_s;
    logic              c0_s;

    // Map the opcode onto a plain adder: second operand and carry-in
    always_comb begin
        b_eff_s = bus.b;
        c0_s    = 1'b0;
        case (bus.op)
            OP_ADD: begin
                b_eff_s = bus.b;
                c0_s    = 1'b0;
            end
            OP_SUB: begin
                b_eff_s = ~bus.b;
                c0_s    = 1'b1;
            end
            OP_INC: begin
                b_eff_s = {WIDTH{1'b0}};
                c0_s    = 1'b1;
            end
            OP_ADC: begin
                b_eff_s = bus.b;
                c0_s    = bus.cin;
            end
            default: begin
                b_eff_s = bus.b;
                c0_s    = 1'b0;
            end
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_entry
            assign src_vld_s[k] = bus.in_valid;
            assign src_a_s[k]   = bus.a;
            assign src_b_s[k]   = b_eff_s;
            assign src_s_s[k]   = {WIDTH{1'b0}};
            assign src_c_s[k]   = c0_s;
        end else begin : g_chain
            assign src_vld_s[k] = vld_q[k-1];
            assign src_a_s[k]   = a_q[k-1];
            assign src_b_s[k]   = b_q[k-1];
            assign src_s_s[k]   = s_q[k-1];
            assign src_c_s[k]   = c_q[k-1];
        end
    end

    // A stage can take a beat unless it and every stage after it are full and the consumer stalls
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if ((vld_q >> k) == (ALL_VALID >> k)) begin
                rdy_s[k] = bus.out_ready;
            end else begin
                rdy_s[k] = 1'b1;
            end
        end
    end

    // Per-stage SEG-bit ripple; the last stage also derives the flags from the full sum
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            seg_s[k] = {1'b0, src_a_s[k][k*SEG +: SEG]}
                     + {1'b0, src_b_s[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, src_c_s[k]};
            s_d[k]   = src_s_s[k];
            s_d[k][k*SEG +: SEG] = seg_s[k][SEG-1:0];
        end
        ovf_d  = (src_a_s[L][WIDTH-1] == src_b_s[L][WIDTH-1])
               & (s_d[L][WIDTH-1] != src_a_s[L][WIDTH-1]);
        zero_d = (s_d[L] == {WIDTH{1'b0}});
    end

    // Advance each stage whenever it is ready; payload only moves with a valid beat
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= {STAGES{1'b0}};
            c_q    <= {STAGES{1'b0}};
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= {WIDTH{1'b0}};
                b_q[k] <= {WIDTH{1'b0}};
                s_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy_s[k]) begin
                    vld_q[k] <= src_vld_s[k];
                    if (src_vld_s[k]) begin
                        a_q[k] <= src_a_s[k];
                        b_q[k] <= src_b_s[k];
                        s_q[k] <= s_d[k];
                        c_q[k] <= seg_s[k][SEG];
                    end
                end
            end
            if (rdy_s[L] && src_vld_s[L]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.in_ready  = rdy_s[0];
    assign bus.out_valid = vld_q[L];
    assign bus.sum       = s_q[L];
    assign bus.carry     = c_q[L];
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipe_add_n.sv
// Scoreboard bench for pipe_add_n: three instances (16/4, 32/8, 8/1) share one
// driver; only the selected instance sees in_valid and the random out_ready.
module tb_pipe_add_n;
    logic clock;
    logic reset_n;

    pipe_add_n_if #(.WIDTH(16)) if16 ();
    pipe_add_n_if #(.WIDTH(32)) if32 ();
    pipe_add_n_if #(.WIDTH(8))  if8  ();

    pipe_add_n #(.WIDTH(16), .STAGES(4)) u_dut16 (.clock(clock), .reset_n(reset_n), .bus(if16.slave));
    pipe_add_n #(.WIDTH(32), .STAGES(8)) u_dut32 (.clock(clock), .reset_n(reset_n), .bus(if32.slave));
    pipe_add_n #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clock(clock), .reset_n(reset_n), .bus(if8.slave));

    logic        drv_valid, drv_cin, drv_ordy;
    logic [1:0]  drv_op;
    logic [31:0] drv_a, drv_b;
    int          cur_sel, cur_w, cur_stages;

    logic        mon_in_ready, mon_out_valid, mon_carry, mon_ovf, mon_zero;
    logic [31:0] mon_sum;

    logic [63:0] sb_q [$];
    int          n_vec, n_err;

    assign if16.in_valid  = drv_valid && (cur_sel == 0);
    assign if16.op        = drv_op;
    assign if16.cin       = drv_cin;
    assign if16.a         = drv_a[15:0];
    assign if16.b         = drv_b[15:0];
    assign if16.out_ready = (cur_sel == 0) ? drv_ordy : 1'b1;

    assign if32.in_valid  = drv_valid && (cur_sel == 1);
    assign if32.op        = drv_op;
    assign if32.cin       = drv_cin;
    assign if32.a         = drv_a;
    assign if32.b         = drv_b;
    assign if32.out_ready = (cur_sel == 1) ? drv_ordy : 1'b1;

    assign if8.in_valid   = drv_valid && (cur_sel == 2);
    assign if8.op         = drv_op;
    assign if8.cin        = drv_cin;
    assign if8.a          = drv_a[7:0];
    assign if8.b          = drv_b[7:0];
    assign if8.out_ready  = (cur_sel == 2) ? drv_ordy : 1'b1;

    always_comb begin
        case (cur_sel)
            1: begin
                mon_in_ready = if32.in_ready; mon_out_valid = if32.out_valid; mon_sum = if32.sum;
                mon_carry = if32.carry; mon_ovf = if32.overflow; mon_zero = if32.zero;
            end
            2: begin
                mon_in_ready = if8.in_ready; mon_out_valid = if8.out_valid; mon_sum = {24'd0, if8.sum};
                mon_carry = if8.carry; mon_ovf = if8.overflow; mon_zero = if8.zero;
            end
            default: begin
                mon_in_ready = if16.in_ready; mon_out_valid = if16.out_valid; mon_sum = {16'd0, if16.sum};
                mon_carry = if16.carry; mon_ovf = if16.overflow; mon_zero = if16.zero;
            end
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: unsigned arithmetic for sum/carry, signed arithmetic for overflow
    function automatic logic [63:0] ref_result(input int w, input logic [1:0] op,
                                               input logic [31:0] a_in, input logic [31:0] b_in,
                                               input logic cin);
        longint modv, ua, ub, ures, sa, sb, sres, sum;
        logic   cy, ovf, zr;
        modv = longint'(1) << w;
        ua   = longint'(a_in) & (modv - 1);
        ub   = longint'(b_in) & (modv - 1);
        sa   = (ua >= modv / 2) ? ua - modv : ua;
        sb   = (ub >= modv / 2) ? ub - modv : ub;
        case (op)
            2'b00:   begin ures = ua + ub;     sres = sa + sb; cy = (ures >= modv); end
            2'b01:   begin ures = ua - ub + modv; sres = sa - sb; cy = (ua >= ub); end
            2'b10:   begin ures = ua + 1;      sres = sa + 1;  cy = (ures >= modv); end
            default: begin
                ures = ua + ub + longint'(cin);
                sres = sa + sb + longint'(cin);
                cy   = (ures >= modv);
            end
        endcase
        sum = ures % modv;
        ovf = (sres > modv / 2 - 1) || (sres < -(modv / 2));
        zr  = (sum == 0);
        return {29'd0, ovf, zr, cy, sum[31:0]};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (w=%0d t=%0t)", tag, obs, exp, cur_w, $time);
        end
    endtask

    // One clock of traffic: drive at negedge, then check and update the scoreboard
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic ordy);
        logic [31:0] mask;
        mask = (cur_w == 32) ? 32'hFFFF_FFFF : ((32'd1 << cur_w) - 32'd1);
        @(negedge clock);
        drv_valid = v; drv_op = op; drv_a = a & mask; drv_b = b & mask;
        drv_cin = cin; drv_ordy = ordy;
        #1;
        check_val("in_ready", 64'(mon_in_ready), 64'(ordy || (sb_q.size() < cur_stages)));
        if (sb_q.size() == 0) begin
            check_val("idle_out_valid", 64'(mon_out_valid), 64'd0);
        end else if (mon_out_valid) begin
            check_val("result", {29'd0, mon_ovf, mon_zero, mon_carry, mon_sum}, sb_q[0]);
            if (ordy) void'(sb_q.pop_front());
        end
        if (v && mon_in_ready) sb_q.push_back(ref_result(cur_w, op, a & mask, b & mask, cin));
    endtask

    task automatic one_op_latency(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin);
        int cnt;
        step(1'b1, op, a, b, cin, 1'b1);
        cnt = 0;
        do begin
            step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1);
            cnt++;
        end while (!mon_out_valid && cnt < 20);
        check_val("latency", 64'(cnt), 64'(cur_stages));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 60) begin
            step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1);
            guard++;
        end
        check_val("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic corner_set();
        logic [31:0] maxv, minneg;
        maxv   = (cur_w == 32) ? 32'hFFFF_FFFF : ((32'd1 << cur_w) - 32'd1);
        minneg = 32'd1 << (cur_w - 1);
        one_op_latency(2'b00, maxv, 32'd1, 1'b0);
        one_op_latency(2'b01, minneg, 32'd1, 1'b0);
        one_op_latency(2'b01, 32'd1, 32'd2, 1'b0);
        one_op_latency(2'b10, minneg - 32'd1, 32'd0, 1'b0);
        one_op_latency(2'b11, 32'h0000_1234, 32'h0000_4321, 1'b1);
        drain();
    endtask

    initial begin
        int accepted, guard;
        n_vec = 0; n_err = 0;
        drv_valid = 1'b0; drv_op = 2'b00; drv_a = 32'd0; drv_b = 32'd0;
        drv_cin = 1'b0; drv_ordy = 1'b1;
        cur_sel = 0; cur_w = 16; cur_stages = 4;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_val("rst_out_valid", 64'(mon_out_valid), 64'd0);
        check_val("rst_outputs", {29'd0, mon_ovf, mon_zero, mon_carry, mon_sum}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed corners and latency at 16/4
        corner_set();

        // Fill with consumer stalled: in_ready must drop once four beats are held
        for (int i = 0; i < 6; i++) step(1'b1, 2'b00, 32'(i * 257), 32'd3, 1'b0, 1'b0);
        // Full pipe with accept and consume in the same cycle
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 32'(i * 4099), 32'd77, 1'b0, 1'b1);
        drain();

        // Back-to-back random ops against a random consumer
        accepted = 0; guard = 0;
        while (accepted < 20 && guard < 300) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            step(1'b1, rop, $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
            if (mon_in_ready) accepted++;
            guard++;
        end
        check_val("random_accepted", 64'(accepted), 64'd20);
        drain();

        // Reset with three beats in flight: nothing may emerge afterwards
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 32'(100 + i), 32'd1, 1'b0, 1'b1);
        @(negedge clock);
        reset_n = 1'b0; drv_valid = 1'b0;
        sb_q.delete();
        #1;
        check_val("mid_rst_out_valid", 64'(mon_out_valid), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1);
        one_op_latency(2'b00, 32'h0000_00FF, 32'h0000_0F01, 1'b0);
        drain();

        // Same corners at 32/8 and at 8/1
        cur_sel = 1; cur_w = 32; cur_stages = 8;
        corner_set();
        cur_sel = 2; cur_w = 8; cur_stages = 1;
        corner_set();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
